lfsr_core: RTL and testbench

Parameterized LFSR engine that advances an arbitrary-width shift register by DATA_WIDTH bit-steps per clock, folding a parallel data word through it. It serves as the scrambler, descrambler, PRBS generator and CRC kernel in the Ethernet PHY datapath, for example 58-bit scrambling of 64-bit 10GBASE-R blocks and PRBS31 generation. It is stateless apart from an output register stage: the caller owns the LFSR state and feeds state_out back into state_in.

---
 rtl/lfsr_core_if.sv | 23 ++
 rtl/lfsr_core.sv | 116 +++++++++++
 tb/tb_lfsr_core.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_core_if.sv
// Word-level port bundle for lfsr_core: request (en, data_in, state_in) and
// registered result (data_out, state_out, out_valid).
interface lfsr_core_if #(
   parameter int LFSR_WIDTH = 31,
   parameter int DATA_WIDTH = 8
);
   logic                  en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [LFSR_WIDTH-1:0] state_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic [LFSR_WIDTH-1:0] state_out;
   logic                  out_valid;

   modport master (
      output en, data_in, state_in,
      input  data_out, state_out, out_valid
   );

   modport slave (
      input  en, data_in, state_in,
      output data_out, state_out, out_valid
   );
endinterface

// File: rtl/lfsr_core.sv
// Multi-bit-per-clock LFSR kernel (scrambler / descrambler / PRBS / CRC) with one output register stage.
// Galois support is compiled in only when LFSR_GALOIS_EN is defined.
module lfsr_core #(
   parameter int                    LFSR_WIDTH        = 31,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
   parameter                        LFSR_CONFIG       = "FIBONACCI",
   parameter int                    LFSR_FEED_FORWARD = 0,
   parameter int                    REVERSE           = 0,
   parameter int                    DATA_WIDTH        = 8,
   parameter                        STYLE             = "AUTO"
) (
   input logic        clk,
   input logic        rst_n,
   lfsr_core_if.slave bus
);

   if (LFSR_WIDTH < 2) begin : g_err_width
      $error("lfsr_core: LFSR_WIDTH must be at least 2");
   end
   if (DATA_WIDTH < 1) begin : g_err_dwidth
      $error("lfsr_core: DATA_WIDTH must be at least 1");
   end
   if (LFSR_CONFIG != "FIBONACCI" && LFSR_CONFIG != "GALOIS") begin : g_err_config
      $error("lfsr_core: LFSR_CONFIG must be FIBONACCI or GALOIS");
   end
   if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_err_style
      $error("lfsr_core: STYLE must be AUTO, LOOP or REDUCTION");
   end

`ifdef LFSR_GALOIS_EN
   localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");
`else
   localparam bit GALOIS = 1'b0;
   if (LFSR_CONFIG == "GALOIS") begin : g_err_galois
      $error("lfsr_core: GALOIS requires LFSR_GALOIS_EN");
   end
`endif

   localparam bit FEED_FWD = (LFSR_FEED_FORWARD != 0);

   // Bit 0 and the implicit x^W term never act as taps.
   localparam logic [LFSR_WIDTH-1:0] TAPS     = LFSR_POLY & ~LFSR_WIDTH'(1);
   localparam logic [LFSR_WIDTH-1:0] FIB_MASK = TAPS >> 1;

   logic [DATA_WIDTH-1:0] data_core_in;
   logic [LFSR_WIDTH-1:0] state_core_in;
   logic [DATA_WIDTH-1:0] data_core_out;
   logic [LFSR_WIDTH-1:0] state_core_out;
   logic [DATA_WIDTH-1:0] data_next;
   logic [LFSR_WIDTH-1:0] state_next;

   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_data_order
      if (REVERSE != 0) begin : g_rev
         assign data_core_in[k] = bus.data_in[DATA_WIDTH-1-k];
         assign data_next[k]    = data_core_out[DATA_WIDTH-1-k];
      end else begin : g_fwd
         assign data_core_in[k] = bus.data_in[k];
         assign data_next[k]    = data_core_out[k];
      end
   end

   for (genvar k = 0; k < LFSR_WIDTH; k++) begin : g_state_order
      if (REVERSE != 0) begin : g_rev
         assign state_core_in[k] = bus.state_in[LFSR_WIDTH-1-k];
         assign state_next[k]    = state_core_out[LFSR_WIDTH-1-k];
      end else begin : g_fwd
         assign state_core_in[k] = bus.state_in[k];
         assign state_next[k]    = state_core_out[k];
      end
   end

   logic fb;

   // Unrolled bit-serial stepping, MSB of the data word first.
   always_comb begin
      fb             = 1'b0;
      state_core_out = state_core_in;
      data_core_out  = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         fb = state_core_out[LFSR_WIDTH-1] ^ data_core_in[i];
         if (!GALOIS) begin
            fb = fb ^ (^(state_core_out & FIB_MASK));
         end
         state_core_out = {state_core_out[LFSR_WIDTH-2:0], FEED_FWD ? data_core_in[i] : fb};
`ifdef LFSR_GALOIS_EN
         if (GALOIS && !FEED_FWD) begin
            state_core_out = state_core_out ^ (TAPS & {LFSR_WIDTH{fb}});
         end
`endif
         data_core_out = (data_core_out << 1) | DATA_WIDTH'(fb);
      end
   end

   logic [DATA_WIDTH-1:0] data_q;
   logic [LFSR_WIDTH-1:0] state_q;
   logic                  valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         state_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.en;
         if (bus.en) begin
            data_q  <= data_next;
            state_q <= state_next;
         end
      end
   end

   assign bus.data_out  = data_q;
   assign bus.state_out = state_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_lfsr_core.sv
// Bench for lfsr_core: several parameterisations checked every cycle against a
// bit-serial reference model, plus hand-computed vectors and a scramble/descramble round trip.
module tb_lfsr_core;

`ifdef LFSR_GALOIS_EN
   localparam int N_DUT = 6;
`else
   localparam int N_DUT = 5;
`endif

   // dut0: W4 fib dw1, dut1: W4 fib dw4, dut2: W4 fib ff dw1,
   // dut3: 58-bit scrambler, dut4: 58-bit descrambler, dut5: W4 galois dw1
   localparam int          CW   [6] = '{4, 4, 4, 58, 58, 4};
   localparam int          CDW  [6] = '{1, 4, 1, 64, 64, 1};
   localparam logic [63:0] CPOLY[6] = '{64'd3, 64'd3, 64'd3, 64'h8000000001, 64'h8000000001, 64'd3};
   localparam bit          CGAL [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam bit          CFF  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam bit          CREV [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        en_v  [N_DUT];
   logic [63:0] din_v [N_DUT];
   logic [63:0] sin_v [N_DUT];
   logic [63:0] dout_w[N_DUT];
   logic [63:0] sout_w[N_DUT];
   logic        vout_w[N_DUT];

   int n_checks = 0;
   int n_err    = 0;

   lfsr_core_if #(.LFSR_WIDTH(4), .DATA_WIDTH(1)) if_a ();
   lfsr_core_if #(.LFSR_WIDTH(4), .DATA_WIDTH(4)) if_b ();
   lfsr_core_if #(.LFSR_WIDTH(4), .DATA_WIDTH(1)) if_c ();
   lfsr_core_if #(.LFSR_WIDTH(58), .DATA_WIDTH(64)) if_s ();
   lfsr_core_if #(.LFSR_WIDTH(58), .DATA_WIDTH(64)) if_d ();

   lfsr_core #(.LFSR_WIDTH(4), .LFSR_POLY(4'd3), .LFSR_CONFIG("FIBONACCI"),
      .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1), .STYLE("AUTO"))
      u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   lfsr_core #(.LFSR_WIDTH(4), .LFSR_POLY(4'd3), .LFSR_CONFIG("FIBONACCI"),
      .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(4), .STYLE("LOOP"))
      u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   lfsr_core #(.LFSR_WIDTH(4), .LFSR_POLY(4'd3), .LFSR_CONFIG("FIBONACCI"),
      .LFSR_FEED_FORWARD(1), .REVERSE(0), .DATA_WIDTH(1), .STYLE("REDUCTION"))
      u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
   lfsr_core #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
      .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(64), .STYLE("AUTO"))
      u_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
   lfsr_core #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
      .LFSR_FEED_FORWARD(1), .REVERSE(1), .DATA_WIDTH(64), .STYLE("AUTO"))
      u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

   assign if_a.en = en_v[0];  assign if_a.data_in = din_v[0][0:0];  assign if_a.state_in = sin_v[0][3:0];
   assign if_b.en = en_v[1];  assign if_b.data_in = din_v[1][3:0];  assign if_b.state_in = sin_v[1][3:0];
   assign if_c.en = en_v[2];  assign if_c.data_in = din_v[2][0:0];  assign if_c.state_in = sin_v[2][3:0];
   assign if_s.en = en_v[3];  assign if_s.data_in = din_v[3];       assign if_s.state_in = sin_v[3][57:0];
   assign if_d.en = en_v[4];  assign if_d.data_in = din_v[4];       assign if_d.state_in = sin_v[4][57:0];

   assign dout_w[0] = 64'(if_a.data_out); assign sout_w[0] = 64'(if_a.state_out); assign vout_w[0] = if_a.out_valid;
   assign dout_w[1] = 64'(if_b.data_out); assign sout_w[1] = 64'(if_b.state_out); assign vout_w[1] = if_b.out_valid;
   assign dout_w[2] = 64'(if_c.data_out); assign sout_w[2] = 64'(if_c.state_out); assign vout_w[2] = if_c.out_valid;
   assign dout_w[3] = if_s.data_out;      assign sout_w[3] = 64'(if_s.state_out); assign vout_w[3] = if_s.out_valid;
   assign dout_w[4] = if_d.data_out;      assign sout_w[4] = 64'(if_d.state_out); assign vout_w[4] = if_d.out_valid;

`ifdef LFSR_GALOIS_EN
   lfsr_core_if #(.LFSR_WIDTH(4), .DATA_WIDTH(1)) if_g ();
   lfsr_core #(.LFSR_WIDTH(4), .LFSR_POLY(4'd3), .LFSR_CONFIG("GALOIS"),
      .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1), .STYLE("AUTO"))
      u_g (.clk(clk), .rst_n(rst_n), .bus(if_g));
   assign if_g.en = en_v[5];  assign if_g.data_in = din_v[5][0:0];  assign if_g.state_in = sin_v[5][3:0];
   assign dout_w[5] = 64'(if_g.data_out); assign sout_w[5] = 64'(if_g.state_out); assign vout_w[5] = if_g.out_valid;
`endif

   // Reference: walk the register one bit at a time exactly as the step rules read.
   function automatic void model(input int w, input int dw, input logic [63:0] poly,
                                 input bit gal, input bit ff, input bit rev,
                                 input logic [63:0] din, input logic [63:0] sin,
                                 output logic [63:0] dout, output logic [63:0] sout);
      logic [63:0] s, d, o, ns;
      bit b, f;
      s = '0; d = '0; o = '0;
      for (int k = 0; k < dw; k++) d[k] = rev ? din[dw-1-k] : din[k];
      for (int k = 0; k < w; k++)  s[k] = rev ? sin[w-1-k] : sin[k];
      for (int i = dw - 1; i >= 0; i--) begin
         b = d[i];
         f = s[w-1] ^ b;
         if (!gal)
            for (int j = 1; j < w; j++) if (poly[j]) f = f ^ s[j-1];
         ns = '0;
         for (int k = 1; k < w; k++) ns[k] = s[k-1];
         ns[0] = ff ? b : f;
         if (gal && !ff)
            for (int j = 1; j < w; j++) if (poly[j]) ns[j] = ns[j] ^ f;
         s = ns;
         o = {o[62:0], f};
      end
      dout = '0; sout = '0;
      for (int k = 0; k < dw; k++) dout[k] = rev ? o[dw-1-k] : o[k];
      for (int k = 0; k < w; k++)  sout[k] = rev ? s[w-1-k] : s[k];
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   logic [63:0] exp_d[N_DUT];
   logic [63:0] exp_s[N_DUT];
   logic        exp_v[N_DUT];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < N_DUT; i++) begin
         if (!rst_n) begin
            exp_d[i] = '0; exp_s[i] = '0; exp_v[i] = 1'b0;
         end else begin
            exp_v[i] = en_v[i];
            if (en_v[i])
               model(CW[i], CDW[i], CPOLY[i], CGAL[i], CFF[i], CREV[i],
                     din_v[i], sin_v[i], exp_d[i], exp_s[i]);
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N_DUT; i++) begin
         chk($sformatf("dut%0d.data_out", i),  dout_w[i], exp_d[i]);
         chk($sformatf("dut%0d.state_out", i), sout_w[i], exp_s[i]);
         chk($sformatf("dut%0d.out_valid", i), 64'(vout_w[i]), 64'(exp_v[i]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] orig_q[$];
   logic [63:0] scr_q[$];
   logic [63:0] word;
   logic [63:0] md, ms;

   // {state_in, data_in, state_out, data_out} for the 4-bit, 4-bit-per-cycle instance
   localparam logic [15:0] B_VEC[4] = '{16'h1_0_E_E, 16'h0_0_0_0, 16'h0_8_F_F, 16'h8_0_F_F};

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < N_DUT; i++) begin
         en_v[i] = 1'b0; din_v[i] = '0; sin_v[i] = '0;
      end

      // model pins against hand-worked single steps
      model(4, 1, 64'd3, 1'b0, 1'b0, 1'b0, 64'd0, 64'h1, md, ms);
      chk("pin_fib_state", ms, 64'h3);
      model(4, 4, 64'd3, 1'b0, 1'b0, 1'b0, 64'd0, 64'h1, md, ms);
      chk("pin_fib4_data", md, 64'hE);
      model(4, 1, 64'd3, 1'b1, 1'b0, 1'b0, 64'd0, 64'h8, md, ms);
      chk("pin_gal_state", ms, 64'h3);
      model(4, 1, 64'd3, 1'b0, 1'b1, 1'b0, 64'd1, 64'h0, md, ms);
      chk("pin_ff_state", ms, 64'h1);

      step(); step();
      chk("reset_valid", 64'(vout_w[0]), 64'd0);
      chk("reset_state", sout_w[3], 64'd0);
      chk("reset_data", dout_w[1], 64'd0);
      rst_n = 1'b1;
      step();
      chk("no_en_valid", 64'(vout_w[0]), 64'd0);

      sin_v[0] = 64'h1; din_v[0] = 64'd0; en_v[0] = 1'b1;
      step();
      chk("fib1_state", sout_w[0], 64'h3);
      chk("fib1_data", dout_w[0], 64'h1);
      chk("fib1_valid", 64'(vout_w[0]), 64'd1);
      en_v[0] = 1'b0; sin_v[0] = 64'hA; din_v[0] = 64'h1;
      step();
      chk("hold_state", sout_w[0], 64'h3);
      chk("hold_data", dout_w[0], 64'h1);
      chk("hold_valid", 64'(vout_w[0]), 64'd0);

      for (int v = 0; v < 4; v++) begin
         sin_v[1] = 64'(B_VEC[v][15:12]); din_v[1] = 64'(B_VEC[v][11:8]); en_v[1] = 1'b1;
         step();
         chk($sformatf("fib4_vec%0d_state", v), sout_w[1], 64'(B_VEC[v][7:4]));
         chk($sformatf("fib4_vec%0d_data", v),  dout_w[1], 64'(B_VEC[v][3:0]));
      end
      // back-to-back free run, model-checked each cycle
      for (int v = 0; v < 16; v++) begin
         sin_v[1] = 64'(v); din_v[1] = 64'(15 - v);
         step();
      end
      en_v[1] = 1'b0;

      sin_v[2] = 64'h0; din_v[2] = 64'h1; en_v[2] = 1'b1;
      step();
      chk("ff_state", sout_w[2], 64'h1);
      chk("ff_data", dout_w[2], 64'h1);
      en_v[2] = 1'b0;

`ifdef LFSR_GALOIS_EN
      sin_v[5] = 64'h8; din_v[5] = 64'h0; en_v[5] = 1'b1;
      step();
      chk("gal_state", sout_w[5], 64'h3);
      chk("gal_data", dout_w[5], 64'h1);
      en_v[5] = 1'b0;
`endif

      // mid-stream reset
      sin_v[1] = 64'h1; din_v[1] = 64'h0; en_v[1] = 1'b1;
      step();
      chk("pre_rst_state", sout_w[1], 64'hE);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_state", sout_w[1], 64'd0);
      chk("rst_mid_data", dout_w[1], 64'd0);
      chk("rst_mid_valid", 64'(vout_w[1]), 64'd0);
      step();
      #2 rst_n = 1'b1;
      step();
      chk("post_rst_valid", 64'(vout_w[1]), 64'd1);
      chk("post_rst_state", sout_w[1], 64'hE);
      en_v[1] = 1'b0;

      // 10GBASE-R style scramble, all-ones seed, state fed back
      sin_v[3] = 64'h03FF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 100; k++) begin
         word = {$urandom, $urandom};
         orig_q.push_back(word);
         din_v[3] = word; en_v[3] = 1'b1;
         step();
         scr_q.push_back(dout_w[3]);
         sin_v[3] = sout_w[3];
      end
      en_v[3] = 1'b0;

      sin_v[4] = 64'h03FF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 100; k++) begin
         din_v[4] = scr_q[k]; en_v[4] = 1'b1;
         step();
         chk($sformatf("descramble%0d", k), dout_w[4], orig_q[k]);
         sin_v[4] = sout_w[4];
      end
      en_v[4] = 1'b0;

      step(); step();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
